// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the fetch
// stage into a small circular FIFO and restarts at a branch target on redirect.
// A redirect that arrives while a memory request is still open waits in
// DISCARD for that request to finish, so the memory handshake is never broken.
module imem_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    S_FILL    = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        next_pc_q, next_pc_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic               outstanding_q, outstanding_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        pc_mem_d    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];

  logic               fire_c;
  logic               enq_c;
  logic               pop_c;
  logic [31:0]        target_c;

  // Head of the FIFO is presented straight from storage.
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];

  // Memory request: held in DISCARD until the stale ack, otherwise whenever
  // there is room or a request is already open (keeps the handshake stable).
  always_comb begin
    mem_req  = (state_q == S_DISCARD) || (count_q != FULL_CNT) || outstanding_q;
    mem_addr = next_pc_q;
    fire_c   = mem_req & mem_ack;
    target_c = redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state, pointer, count and storage update.
  always_comb begin
    state_d       = state_q;
    next_pc_d     = next_pc_q;
    pend_pc_d     = pend_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = mem_req & ~mem_ack;
    enq_c         = 1'b0;
    pop_c         = 1'b0;
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;

    if (redirect) begin
      // Flush; an open request that is not finishing now must be drained.
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pend_pc_d = target_c;
      if (mem_req && !mem_ack) begin
        state_d = S_DISCARD;
      end else begin
        state_d   = S_FILL;
        next_pc_d = target_c;
      end
    end else if (state_q == S_DISCARD) begin
      // Drop the stale data and restart at the newest pending target.
      if (mem_ack) begin
        state_d   = S_FILL;
        next_pc_d = pend_pc_q;
      end
    end else begin
      enq_c = fire_c;
      pop_c = deq && (count_q != '0);
      if (enq_c) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        next_pc_d = next_pc_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + CNT_W'(enq_c) - CNT_W'(pop_c);
    end

    if (enq_c) begin
      pc_mem_d[wr_ptr_q]    = next_pc_q;
      instr_mem_d[wr_ptr_q] = mem_rdata;
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FILL;
      next_pc_q     <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      outstanding_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      next_pc_q     <= next_pc_d;
      pend_pc_q     <= pend_pc_d;
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Testbench for imem_prefetch_queue: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_imem_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  imem_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq(deq), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: the expected FIFO contents plus fetch bookkeeping.
  ent_t        mq[$];
  logic [31:0] m_next;
  logic [31:0] m_pend;
  bit          m_disc;
  bit          checking = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return m_disc || (mq.size() < DEPTH);
  endfunction

  // Model update: applies the sampled inputs at every rising edge.
  always @(posedge clk) begin : model
    bit          req;
    logic [31:0] tgt;
    req = model_req();
    tgt = {redirect_pc[31:2], 2'b00};
    if (!reset) begin
      mq.delete();
      m_next = RESET_PC;
      m_pend = RESET_PC;
      m_disc = 1'b0;
    end else if (redirect) begin
      mq.delete();
      if (req && !mem_ack) begin
        m_disc = 1'b1;
        m_pend = tgt;
      end else begin
        m_disc = 1'b0;
        m_next = tgt;
      end
    end else if (m_disc) begin
      if (mem_ack) begin
        m_disc = 1'b0;
        m_next = m_pend;
      end
    end else begin
      if (deq && mq.size() > 0) void'(mq.pop_front());
      if (req && mem_ack) begin
        mq.push_back(ent_t'{m_next, mem_rdata});
        m_next = m_next + 32'd4;
      end
    end
  end

  // Monitor: compares DUT outputs with the model head away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr_out", instr_out, mq[0].instr);
      end
      chk("mem_req", 32'(mem_req), 32'(model_req()));
      if (model_req()) chk("mem_addr", mem_addr, m_next);
    end
  end

  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit dq, input bit ack);
    redirect    = rd;
    redirect_pc = rpc;
    deq         = dq;
    mem_ack     = ack;
    mem_rdata   = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    deq         = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    // Reset state: cleared storage, request at RESET_PC.
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    cyc(0, 0, 0, 0);
    reset = 1'b1;

    // Streaming at one instruction per cycle.
    repeat (12) cyc(0, 0, 1, 1);

    // Fill to full, then a single dequeue lets one more request through.
    cyc(1, 32'h0, 1, 1);
    repeat (6) cyc(0, 0, 0, 1);
    chk("full_no_req", 32'(mem_req), 32'h0);
    cyc(0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 1);

    // Three entries queued, redirect to 0x100 with deq and a finishing ack.
    cyc(1, 32'h0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 32'h100, 1, 1);
    chk("redir_valid", 32'(instr_valid), 32'h0);
    chk("redir_addr", mem_addr, 32'h100);
    cyc(0, 0, 1, 1);
    chk("redir_head_pc", instr_pc, 32'h100);
    repeat (2) cyc(0, 0, 1, 1);

    // Redirect to 0x200 while the 0x10 request is open (3-cycle latency).
    cyc(1, 32'h0, 1, 1);
    repeat (4) cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h200, 1, 0);
    chk("disc_hold_addr", mem_addr, 32'h10);
    cyc(0, 0, 1, 1);
    chk("disc_next_addr", mem_addr, 32'h200);
    repeat (4) cyc(0, 0, 1, 1);

    // Two redirects inside DISCARD: the newest target wins.
    cyc(0, 0, 1, 0);
    cyc(1, 32'h300, 1, 0);
    cyc(1, 32'h401, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("double_redir_addr", mem_addr, 32'h400);
    repeat (4) cyc(0, 0, 1, 1);

    // Random traffic including occasional resets and spurious acks.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      cyc($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1);
      reset = 1'b1;
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
